// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 2;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = wb_pkg::DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  wb_entry_t              push_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output wb_entry_t              head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // storage array; contents are don't-care while empty so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Sole owner of the register-file write port: merges pipeline WB results with
// queued long-latency results and tracks registers awaiting those results.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN  = wb_pkg::XLEN,
   parameter int DEPTH = wb_pkg::DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_wb_en,
   input  logic [4:0]             pipe_wb_addr,
   input  logic [XLEN-1:0]        pipe_wb_data,
   input  logic                   ll_valid,
   output logic                   ll_ready,
   input  logic [4:0]             ll_addr,
   input  logic [XLEN-1:0]        ll_data,
   input  logic                   issue_valid,
   input  logic [4:0]             issue_rd,
   input  logic [4:0]             id_rs1,
   input  logic [4:0]             id_rs2,
   input  logic [4:0]             id_rd,
   input  logic                   id_rd_we,
   output logic                   hazard,
   output logic                   reg_write,
   output logic [4:0]             wt_addr,
   output logic [XLEN-1:0]        wt_data,
   output logic [31:0]            busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   logic      pe;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_push;
   logic      fifo_pop;
   wb_entry_t fifo_head;
   wb_entry_t ll_entry;

   // address-0 pipeline writes are dropped so they never steal a drain slot
   assign pe        = pipe_wb_en && (pipe_wb_addr != '0);
   assign ll_ready  = !fifo_full;
   assign fifo_push = ll_valid && ll_ready;
   assign fifo_pop  = !pe && !fifo_empty;
   assign ll_entry  = '{addr: ll_addr, data: ll_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (ll_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // write-port select: pipeline first, then FIFO head, else idle
   always_comb begin
      reg_write = 1'b0;
      wt_addr   = '0;
      wt_data   = '0;
      if (pe) begin
         reg_write = 1'b1;
         wt_addr   = pipe_wb_addr;
         wt_data   = pipe_wb_data;
      end else if (fifo_pop) begin
         reg_write = (fifo_head.addr != '0);
         wt_addr   = fifo_head.addr;
         wt_data   = fifo_head.data;
      end
      if (rst) begin
         reg_write = 1'b0;
      end
   end

   // scoreboard: the set is applied last so it wins over a same-edge clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (fifo_pop && (fifo_head.addr != '0)) busy[fifo_head.addr] <= 1'b0;
         if (issue_valid && (issue_rd != '0))    busy[issue_rd]       <= 1'b1;
      end
   end

   // stall request from registered busy; conservative for a same-cycle clear
   always_comb begin
      hazard = 1'b0;
      if ((id_rs1 != '0) && busy[id_rs1])                hazard = 1'b1;
      if ((id_rs2 != '0) && busy[id_rs2])                hazard = 1'b1;
      if (id_rd_we && (id_rd != '0) && busy[id_rd])      hazard = 1'b1;
      if (issue_valid && (issue_rd != '0) && busy[issue_rd]) hazard = 1'b1;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_wb_arbiter;

   localparam int XW = 32;
   localparam int DP = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            pipe_wb_en;
   logic [4:0]      pipe_wb_addr;
   logic [XW-1:0]   pipe_wb_data;
   logic            ll_valid;
   logic            ll_ready;
   logic [4:0]      ll_addr;
   logic [XW-1:0]   ll_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic            id_rd_we;
   logic            hazard;
   logic            reg_write;
   logic [4:0]      wt_addr;
   logic [XW-1:0]   wt_data;
   logic [31:0]     busy;
   logic [1:0]      fifo_count;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst),
      .pipe_wb_en(pipe_wb_en), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .hazard(hazard), .reg_write(reg_write), .wt_addr(wt_addr), .wt_data(wt_data),
      .busy(busy), .fifo_count(fifo_count)
   );

   typedef struct {
      logic [4:0]    addr;
      logic [XW-1:0] data;
   } ent_t;

   int          checks = 0;
   int          errors = 0;
   ent_t        mq[$];
   logic [31:0] mbusy;
   logic [4:0]  wr_log[$];
   logic        ll_acc;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_idle();
      pipe_wb_en   = 1'b0;
      pipe_wb_addr = '0;
      pipe_wb_data = '0;
      ll_valid     = 1'b0;
      ll_addr      = '0;
      ll_data      = '0;
      issue_valid  = 1'b0;
      issue_rd     = '0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
      id_rd_we     = 1'b0;
   endtask

   // one clock: compare outputs before the edge, then advance the model
   task automatic step();
      logic          pe, rdy, pop, erw, ehz;
      logic          s_llv, s_iv;
      logic [4:0]    ea, s_lla, s_ird;
      logic [XW-1:0] ed, s_lld;
      ent_t          h;
      @(negedge clk);
      s_llv = ll_valid; s_lla = ll_addr; s_lld = ll_data;
      s_iv  = issue_valid; s_ird = issue_rd;
      pe  = pipe_wb_en && (pipe_wb_addr != 0);
      rdy = (mq.size() < DP);
      pop = !pe && (mq.size() > 0);
      erw = 1'b0; ea = '0; ed = '0;
      if (pe) begin
         erw = 1'b1; ea = pipe_wb_addr; ed = pipe_wb_data;
      end else if (pop) begin
         erw = (mq[0].addr != 0); ea = mq[0].addr; ed = mq[0].data;
      end
      ehz = ((id_rs1 != 0) && mbusy[id_rs1]) || ((id_rs2 != 0) && mbusy[id_rs2]) ||
            (id_rd_we && (id_rd != 0) && mbusy[id_rd]) ||
            (s_iv && (s_ird != 0) && mbusy[s_ird]);
      check_val("reg_write",  64'(reg_write),  64'(erw));
      check_val("wt_addr",    64'(wt_addr),    64'(ea));
      check_val("wt_data",    64'(wt_data),    64'(ed));
      check_val("ll_ready",   64'(ll_ready),   64'(rdy));
      check_val("hazard",     64'(hazard),     64'(ehz));
      check_val("busy",       64'(busy),       64'(mbusy));
      check_val("fifo_count", 64'(fifo_count), 64'(mq.size()));
      if (reg_write) wr_log.push_back(wt_addr);
      @(posedge clk);
      if (pop) begin
         h = mq.pop_front();
         if (h.addr != 0) mbusy[h.addr] = 1'b0;
      end
      if (s_llv && rdy) mq.push_back('{s_lla, s_lld});
      if (s_iv && (s_ird != 0)) mbusy[s_ird] = 1'b1;
      ll_acc = s_llv && rdy;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      mq.delete();
      mbusy = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [4:0] order [3];
      int         idx;
      order[0] = 5'd3; order[1] = 5'd4; order[2] = 5'd9;
      mbusy  = '0;
      ll_acc = 1'b0;
      rst    = 1'b1;
      drive_idle();
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd5;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_reg_write",  64'(reg_write),  64'd0);
      check_val("rst_fifo_count", 64'(fifo_count), 64'd0);
      check_val("rst_busy",       64'(busy),       64'd0);
      check_val("rst_ll_ready",   64'(ll_ready),   64'd1);
      rst = 1'b0;

      // pipeline write goes straight through
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'h1234;
      step();

      // arbitration: long-latency entry waits behind three pe cycles
      drive_idle();
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      issue_valid = 1'b0;
      check_val("busy7_set", 64'(busy[7]), 64'd1);
      id_rs1 = 5'd7;
      #1 check_val("hazard_rs1", 64'(hazard), 64'd1);
      step();
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1; pipe_wb_data = $urandom;
      ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'hDEAD;
      step();
      ll_valid = 1'b0;
      step();
      step();
      pipe_wb_en = 1'b0;
      wr_log.delete();
      step();
      check_val("arb_wr_cnt",  64'(wr_log.size()), 64'd1);
      if (wr_log.size() > 0) check_val("arb_wr_addr", 64'(wr_log[0]), 64'd7);
      check_val("busy7_clr", 64'(busy[7]), 64'd0);

      // full and ordering under continuous pe
      drive_idle();
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1; pipe_wb_data = 32'h55;
      idx = 0;
      ll_valid = 1'b1; ll_addr = order[0]; ll_data = 32'h300;
      for (int c = 0; c < 8; c++) begin
         if (c == 4) begin
            check_val("full_count", 64'(fifo_count), 64'd2);
            check_val("full_ready", 64'(ll_ready),   64'd0);
            check_val("full_held",  64'(ll_addr),    64'd9);
            pipe_wb_en = 1'b0;
            wr_log.delete();
         end
         step();
         if (ll_acc) begin
            idx++;
            if (idx < 3) begin
               ll_addr = order[idx]; ll_data = 32'h300 + 32'(idx);
            end else begin
               ll_valid = 1'b0;
            end
         end
      end
      check_val("order_cnt", 64'(wr_log.size()), 64'd3);
      for (int k = 0; k < 3; k++)
         if (k < wr_log.size()) check_val("order_addr", 64'(wr_log[k]), 64'(order[k]));

      // set/clear collision on the same register
      drive_idle();
      issue_valid = 1'b1; issue_rd = 5'd6;
      step();
      issue_valid = 1'b0;
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1;
      ll_valid = 1'b1; ll_addr = 5'd6; ll_data = 32'h66;
      step();
      drive_idle();
      issue_valid = 1'b1; issue_rd = 5'd6;
      step();
      issue_valid = 1'b0;
      check_val("collide_busy6", 64'(busy[6]), 64'd1);

      // address 0 on both sources
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1;
      ll_valid = 1'b1; ll_addr = 5'd2; ll_data = 32'h22;
      step();
      ll_valid = 1'b0;
      pipe_wb_addr = 5'd0;
      wr_log.delete();
      step();
      check_val("a0_pipe_drop", 64'(wr_log.size() == 1 && wr_log[0] == 5'd2), 64'd1);
      pipe_wb_addr = 5'd1;
      ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'hABCD;
      step();
      drive_idle();
      wr_log.delete();
      step();
      check_val("a0_ll_nowrite", 64'(wr_log.size()), 64'd0);
      check_val("a0_ll_count",   64'(fifo_count),    64'd0);

      // write-after-write hazard
      issue_valid = 1'b1; issue_rd = 5'd8;
      step();
      issue_valid = 1'b0;
      id_rd_we = 1'b1; id_rd = 5'd8;
      #1 check_val("waw_hazard", 64'(hazard), 64'd1);
      step();

      // random traffic
      drive_idle();
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) mbusy = mbusy;
         pipe_wb_en   = ($urandom_range(0, 99) < 45);
         pipe_wb_addr = 5'($urandom_range(0, 31));
         pipe_wb_data = $urandom;
         issue_valid  = ($urandom_range(0, 99) < 20);
         issue_rd     = 5'($urandom_range(0, 31));
         id_rs1       = 5'($urandom_range(0, 31));
         id_rs2       = 5'($urandom_range(0, 31));
         id_rd        = 5'($urandom_range(0, 31));
         id_rd_we     = 1'($urandom_range(0, 1));
         if (!ll_valid && ($urandom_range(0, 99) < 40)) begin
            ll_valid = 1'b1;
            ll_addr  = 5'($urandom_range(0, 31));
            ll_data  = $urandom;
         end
         step();
         if (ll_acc) ll_valid = 1'b0;
      end

      // asynchronous reset with two queued entries and busy = 0x90
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd4;
      step();
      issue_rd = 5'd7;
      step();
      issue_valid = 1'b0;
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1;
      ll_valid = 1'b1; ll_addr = 5'd10; ll_data = 32'hA;
      step();
      ll_addr = 5'd11; ll_data = 32'hB;
      step();
      ll_valid = 1'b0;
      check_val("pre_rst_count", 64'(fifo_count), 64'd2);
      check_val("pre_rst_busy",  64'(busy),       64'h90);
      #2 rst = 1'b1;
      #1;
      check_val("arst_count",     64'(fifo_count), 64'd0);
      check_val("arst_busy",      64'(busy),       64'd0);
      check_val("arst_reg_write", 64'(reg_write),  64'd0);
      check_val("arst_ll_ready",  64'(ll_ready),   64'd1);
      mq.delete();
      mbusy = '0;
      drive_idle();
      @(posedge clk);
      #1 rst = 1'b0;
      wr_log.delete();
      repeat (4) step();
      check_val("post_rst_nowrite", 64'(wr_log.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
